alu_muldiv: RTL and testbench

//   Parametrised execute unit: RV32I ALU ops plus RV32M multiply/divide.

---
 rtl/alu_muldiv.sv | 224 ++++++++++++++++++++++
 tb/tb_alu_muldiv.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_muldiv.sv
// alu_muldiv: RV32I ALU plus RV32M multiply/divide execute unit.
// Single-cycle ops and divide shortcuts register their result in one cycle;
// MUL*/DIV* iterate one bit per cycle on operand magnitudes, then sign-fix.
module alu_muldiv #(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [4:0]      op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            zero,
    output logic            illegal
);

    localparam int unsigned SHAMT_W = $clog2(XLEN);
    localparam int unsigned CNT_W   = $clog2(XLEN + 1);
    localparam logic [XLEN-1:0] MinVal  = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [XLEN-1:0] AllOnes = {XLEN{1'b1}};

    localparam logic [4:0] OpAdd    = 5'b00000;
    localparam logic [4:0] OpSub    = 5'b00001;
    localparam logic [4:0] OpAnd    = 5'b00010;
    localparam logic [4:0] OpOr     = 5'b00011;
    localparam logic [4:0] OpXor    = 5'b00100;
    localparam logic [4:0] OpSll    = 5'b00101;
    localparam logic [4:0] OpSrl    = 5'b00110;
    localparam logic [4:0] OpSra    = 5'b00111;
    localparam logic [4:0] OpSlt    = 5'b01000;
    localparam logic [4:0] OpSltu   = 5'b01001;
    localparam logic [4:0] OpMulh   = 5'b10001;
    localparam logic [4:0] OpMulhsu = 5'b10010;
    localparam logic [4:0] OpDiv    = 5'b10100;
    localparam logic [4:0] OpRem    = 5'b10110;

    typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [4:0]        op_q, op_d;
    logic [XLEN-1:0]   mcand_q, mcand_d;   // multiplicand or divisor magnitude
    logic [XLEN-1:0]   hi_q, hi_d;         // product high half or partial remainder
    logic [XLEN-1:0]   lo_q, lo_d;         // multiplier/product low half or quotient
    logic              neg_q, neg_d;
    logic [XLEN-1:0]   result_q, result_d;
    logic              zero_q, zero_d;
    logic              illegal_q, illegal_d;

    logic              accept;
    logic              is_mul, is_div, a_signed, b_signed, a_neg, b_neg;
    logic              div_zero, div_ovf, div_short, iterative;
    logic [XLEN-1:0]   a_mag, b_mag;
    logic [SHAMT_W-1:0] shamt;
    logic [XLEN-1:0]   fast_res;
    logic              legal;

    logic [XLEN:0]     mul_sum;
    logic [XLEN-1:0]   mul_hi_n, mul_lo_n;
    logic [XLEN:0]     div_shift, div_diff;
    logic [XLEN-1:0]   rem_n, quo_n;
    logic [2*XLEN-1:0] prod_s;
    logic [XLEN-1:0]   quo_s, rem_s, fix_res;

    assign accept    = in_valid & in_ready;
    assign is_mul    = (op[4:2] == 3'b100);
    assign is_div    = (op[4:2] == 3'b101);
    assign a_signed  = (op == OpMulh) | (op == OpMulhsu) | (op == OpDiv) | (op == OpRem);
    assign b_signed  = (op == OpMulh) | (op == OpDiv) | (op == OpRem);
    assign a_neg     = a_signed & a[XLEN-1];
    assign b_neg     = b_signed & b[XLEN-1];
    assign a_mag     = a_neg ? (~a + 1'b1) : a;
    assign b_mag     = b_neg ? (~b + 1'b1) : b;
    assign div_zero  = (b == '0);
    assign div_ovf   = ((op == OpDiv) | (op == OpRem)) & (a == MinVal) & (b == AllOnes);
    assign div_short = is_div & (div_zero | div_ovf);
    assign iterative = is_mul | (is_div & ~div_short);
    assign shamt     = b[SHAMT_W-1:0];

    // Single-cycle result: ALU ops, divide shortcuts, and zero for illegal codes
    always_comb begin
        fast_res = '0;
        legal    = 1'b1;
        unique case (op)
            OpAdd:  fast_res = a + b;
            OpSub:  fast_res = a - b;
            OpAnd:  fast_res = a & b;
            OpOr:   fast_res = a | b;
            OpXor:  fast_res = a ^ b;
            OpSll:  fast_res = a << shamt;
            OpSrl:  fast_res = a >> shamt;
            OpSra:  fast_res = $unsigned($signed(a) >>> shamt);
            OpSlt:  fast_res = {{(XLEN-1){1'b0}}, ($signed(a) < $signed(b))};
            OpSltu: fast_res = {{(XLEN-1){1'b0}}, (a < b)};
            default: begin
                if (is_div) begin
                    // op[1] selects remainder over quotient
                    if (div_zero)     fast_res = op[1] ? a : AllOnes;
                    else if (div_ovf) fast_res = op[1] ? '0 : MinVal;
                end else if (!is_mul) begin
                    legal = 1'b0;
                end
            end
        endcase
    end

    // One shift-add or restoring-subtract step plus final sign fix-up
    always_comb begin
        mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, mcand_q} : '0);
        mul_hi_n  = mul_sum[XLEN:1];
        mul_lo_n  = {mul_sum[0], lo_q[XLEN-1:1]};
        div_shift = {hi_q, lo_q[XLEN-1]};
        div_diff  = div_shift - {1'b0, mcand_q};
        rem_n     = div_diff[XLEN] ? div_shift[XLEN-1:0] : div_diff[XLEN-1:0];
        quo_n     = {lo_q[XLEN-2:0], ~div_diff[XLEN]};
        prod_s    = neg_q ? (~{mul_hi_n, mul_lo_n} + 1'b1) : {mul_hi_n, mul_lo_n};
        quo_s     = neg_q ? (~quo_n + 1'b1) : quo_n;
        rem_s     = neg_q ? (~rem_n + 1'b1) : rem_n;
        if (op_q[4:2] == 3'b100) begin
            fix_res = (op_q[1:0] == 2'b00) ? prod_s[XLEN-1:0] : prod_s[2*XLEN-1:XLEN];
        end else begin
            fix_res = op_q[1] ? rem_s : quo_s;
        end
    end

    // State register and datapath registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            op_q      <= '0;
            mcand_q   <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            neg_q     <= 1'b0;
            result_q  <= '0;
            zero_q    <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            op_q      <= op_d;
            mcand_q   <= mcand_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            neg_q     <= neg_d;
            result_q  <= result_d;
            zero_q    <= zero_d;
            illegal_q <= illegal_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (accept) state_d = iterative ? StBusy : StDone;
            StBusy:  if (cnt_q == CNT_W'(1)) state_d = StDone;
            StDone:  if (out_ready) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Datapath next-state: capture on accept, iterate in BUSY, hold in DONE
    always_comb begin
        cnt_d     = cnt_q;
        op_d      = op_q;
        mcand_d   = mcand_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        neg_d     = neg_q;
        result_d  = result_q;
        zero_d    = zero_q;
        illegal_d = illegal_q;
        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    op_d      = op;
                    illegal_d = ~legal;
                    hi_d      = '0;
                    if (iterative) begin
                        cnt_d   = CNT_W'(XLEN);
                        mcand_d = is_mul ? a_mag : b_mag;
                        lo_d    = is_mul ? b_mag : a_mag;
                        // Remainder follows the dividend sign only
                        neg_d   = (is_div & op[1]) ? a_neg : (a_neg ^ b_neg);
                    end else begin
                        result_d = fast_res;
                        zero_d   = (fast_res == '0);
                    end
                end
            end
            StBusy: begin
                cnt_d = cnt_q - 1'b1;
                if (op_q[4:2] == 3'b100) begin
                    hi_d = mul_hi_n;
                    lo_d = mul_lo_n;
                end else begin
                    hi_d = rem_n;
                    lo_d = quo_n;
                end
                if (cnt_q == CNT_W'(1)) begin
                    result_d = fix_res;
                    zero_d   = (fix_res == '0);
                end
            end
            default: ;
        endcase
    end

    // Outputs
    always_comb begin
        in_ready  = (state_q == StIdle);
        out_valid = (state_q == StDone);
        result    = result_q;
        zero      = zero_q;
        illegal   = illegal_q;
    end

endmodule

// File: tb/tb_alu_muldiv.sv
// Scoreboard bench for alu_muldiv: driver pushes model results, monitor pops on handshake.
module tb_alu_muldiv;

    localparam int XLEN = 32;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  op;
    logic [31:0] a, b;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic        zero;
    logic        illegal;

    alu_muldiv #(.XLEN(XLEN)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .zero      (zero),
        .illegal   (illegal)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] res;
        logic        ill;
        int          lat;
        int          acc;
        logic [4:0]  op;
    } exp_t;

    exp_t sb[$];
    int   tests = 0;
    int   fails = 0;
    int   cyc = 0;
    logic force_low = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endfunction

    // Reference model straight from the ISA definitions
    function automatic void model(input logic [4:0] o, input logic [31:0] x, input logic [31:0] y,
                                  output logic [31:0] r, output logic ill, output int lat);
        longint      sx, sy, ux, uy;
        logic [63:0] p;
        int          ix, iy;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        ux = longint'({32'b0, x});
        uy = longint'({32'b0, y});
        ix = $signed(x);
        iy = $signed(y);
        r = '0; ill = 1'b0; lat = 1;
        case (o)
            5'b00000: r = x + y;
            5'b00001: r = x - y;
            5'b00010: r = x & y;
            5'b00011: r = x | y;
            5'b00100: r = x ^ y;
            5'b00101: r = x << y[4:0];
            5'b00110: r = x >> y[4:0];
            5'b00111: r = $unsigned(ix >>> y[4:0]);
            5'b01000: r = (ix < iy) ? 32'd1 : 32'd0;
            5'b01001: r = (x < y) ? 32'd1 : 32'd0;
            5'b10000: begin p = ux * uy; r = p[31:0];  lat = 33; end
            5'b10001: begin p = sx * sy; r = p[63:32]; lat = 33; end
            5'b10010: begin p = sx * uy; r = p[63:32]; lat = 33; end
            5'b10011: begin p = ux * uy; r = p[63:32]; lat = 33; end
            5'b10100: begin
                if (y == 0) r = 32'hffffffff;
                else if (x == 32'h80000000 && y == 32'hffffffff) r = 32'h80000000;
                else begin r = ix / iy; lat = 33; end
            end
            5'b10101: begin
                if (y == 0) r = 32'hffffffff;
                else begin r = x / y; lat = 33; end
            end
            5'b10110: begin
                if (y == 0) r = x;
                else if (x == 32'h80000000 && y == 32'hffffffff) r = 32'h0;
                else begin r = ix % iy; lat = 33; end
            end
            5'b10111: begin
                if (y == 0) r = x;
                else begin r = x % y; lat = 33; end
            end
            default: ill = 1'b1;
        endcase
    endfunction

    // Called at posedge+1; returns at posedge+1 after the accept edge
    task automatic issue(input logic [4:0] o, input logic [31:0] x, input logic [31:0] y);
        int   w = 0;
        exp_t e;
        model(o, x, y, e.res, e.ill, e.lat);
        e.op = o;
        in_valid = 1'b1; op = o; a = x; b = y;
        while (!in_ready && w < 200) begin
            @(posedge clk); #1; w++;
        end
        if (!in_ready) begin
            tests++; fails++;
            $display("FAIL accept_timeout: in_ready stuck at 0, required 1");
            in_valid = 1'b0;
            return;
        end
        @(posedge clk); #1;
        e.acc = cyc;
        sb.push_back(e);
        in_valid = 1'b0;
        op = 5'($urandom); a = $urandom; b = $urandom;
    endtask

    task automatic drain();
        int w = 0;
        while (sb.size() > 0 && w < 500) begin
            @(posedge clk); w++;
        end
        #1;
        if (sb.size() > 0) begin
            tests++; fails++;
            $display("FAIL drain_timeout: %0d results outstanding, required 0", sb.size());
            sb.delete();
        end
    endtask

    // Consumer backpressure
    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk); #2;
            out_ready = force_low ? 1'b0 : ($urandom_range(0, 3) != 0);
        end
    end

    // Monitor: checks handshake behaviour each cycle and pops on result transfer
    initial begin
        logic        prev_v = 1'b0;
        int          first_cyc = 0;
        logic [31:0] held = '0;
        exp_t        e;
        forever begin
            @(negedge clk);
            if (reset) begin
                prev_v = 1'b0;
            end else begin
                if (out_valid) begin
                    if (!prev_v) begin
                        first_cyc = cyc;
                        held = result;
                    end else begin
                        check("result_hold", {32'b0, result}, {32'b0, held});
                    end
                    check("in_ready_done", {63'b0, in_ready}, 64'd0);
                    if (out_ready) begin
                        if (sb.size() == 0) begin
                            tests++; fails++;
                            $display("FAIL unexpected_result: got %h, required no output", result);
                        end else begin
                            e = sb.pop_front();
                            check($sformatf("result_op%05b", e.op), {32'b0, result}, {32'b0, e.res});
                            check("zero", {63'b0, zero}, {63'b0, (e.res == 0)});
                            check("illegal", {63'b0, illegal}, {63'b0, e.ill});
                            check($sformatf("latency_op%05b", e.op), 64'(first_cyc - e.acc + 1),
                                  64'(e.lat));
                        end
                    end
                end else if (sb.size() > 0) begin
                    check("in_ready_busy", {63'b0, in_ready}, 64'd0);
                end else begin
                    check("in_ready_idle", {63'b0, in_ready}, 64'd1);
                end
                prev_v = out_valid & ~out_ready;
            end
        end
    end

    logic [4:0] legal_ops [18] = '{5'b00000, 5'b00001, 5'b00010, 5'b00011, 5'b00100, 5'b00101,
                                   5'b00110, 5'b00111, 5'b01000, 5'b01001, 5'b10000, 5'b10001,
                                   5'b10010, 5'b10011, 5'b10100, 5'b10101, 5'b10110, 5'b10111};

    initial begin
        int          w;
        logic [4:0]  ro;
        logic [31:0] ra, rb;
        reset = 1'b1; in_valid = 1'b0; op = '0; a = '0; b = '0;
        #1;
        check("reset_state", {59'b0, out_valid, in_ready, zero, illegal, (result == 0)},
              {59'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1});
        @(posedge clk); #1; reset = 1'b0;
        @(posedge clk); #1;

        issue(5'b00000, 32'h7fffffff, 32'h1);
        issue(5'b00001, 32'h5, 32'h5);
        issue(5'b00111, 32'h80000000, 32'd24);
        issue(5'b10001, 32'hffffffff, 32'h2);
        issue(5'b10011, 32'hffffffff, 32'h2);
        issue(5'b10100, 32'h80000000, 32'hffffffff);
        issue(5'b10110, 32'h80000000, 32'hffffffff);
        issue(5'b10101, 32'h9, 32'h0);
        issue(5'b10111, 32'h9, 32'h0);
        drain();

        // Backpressure: hold the result for several cycles
        issue(5'b10100, 32'hfffffff9, 32'h2);
        force_low = 1'b1;
        w = 0;
        while (!out_valid && w < 100) begin
            @(posedge clk); #1; w++;
        end
        check("div_valid_seen", {63'b0, out_valid}, 64'd1);
        repeat (5) @(posedge clk);
        #1;
        force_low = 1'b0;
        issue(5'b10110, 32'hfffffff9, 32'h2);
        drain();

        // Reset in the middle of an iterative op
        issue(5'b10000, 32'h12345678, 32'h9abcdef0);
        repeat (10) @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        check("abort_out_valid", {63'b0, out_valid}, 64'd0);
        check("abort_in_ready", {63'b0, in_ready}, 64'd1);
        check("abort_result", {32'b0, result}, 64'd0);
        sb.delete();
        @(posedge clk); #1; reset = 1'b0;
        issue(5'b00000, 32'h1, 32'h2);
        issue(5'b01111, 32'h1234, 32'h5678);
        drain();

        // Randomized traffic with biased corner operands
        for (int i = 0; i < 300; i++) begin
            ro = ($urandom_range(0, 9) == 0) ? 5'($urandom) : legal_ops[$urandom_range(0, 17)];
            ra = $urandom;
            rb = $urandom;
            case ($urandom_range(0, 7))
                0: rb = 32'h0;
                1: begin ra = 32'h80000000; rb = 32'hffffffff; end
                2: begin ra = 32'($urandom_range(0, 20)); rb = 32'($urandom_range(0, 20)); end
                3: rb = 32'hffffffff - 32'($urandom_range(0, 3));
                default: ;
            endcase
            issue(ro, ra, rb);
        end
        drain();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
